cirno9_sram_arb: RTL
====================

Name: cirno9_sram_arb

Overview:
Single-port SRAM arbiter for the cirno9 core's unified 32-bit SRAM (u_sram32).
- Shares the SRAM between three requesters: instruction fetch (IFU, read-only), load/store unit (LSU, read/write) and debug/loader port (DBG, read/write, can lock the SRAM).
- Issues at most one SRAM access per cycle and returns responses one cycle later to the requester that was granted.

Parameters:
- AW, 14, word-address width (2^AW 32-bit words).
- STARVE_MAX, 8, number of consecutive IFU denials before IFU is forced to win (fixed-priority mode only).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- ifu_req_valid  input  1  IFU read request.
- ifu_req_ready  output  1  IFU request accepted this cycle.
- ifu_req_addr  input  AW  IFU word address.
- ifu_rsp_valid  output  1  IFU read data valid.
- ifu_rsp_rdata  output  32  IFU read data.
- lsu_req_valid / lsu_req_ready  input/output  1/1  LSU handshake.
- lsu_req_addr / lsu_req_we / lsu_req_wdata / lsu_req_wmask  input  AW/1/32/4  LSU request fields.
- lsu_rsp_valid / lsu_rsp_rdata  output  1/32  LSU response (rdata is don't-care for writes).
- dbg_req_valid / dbg_req_ready  input/output  1/1  DBG handshake.
- dbg_req_addr / dbg_req_we / dbg_req_wdata / dbg_req_wmask  input  AW/1/32/4  DBG request fields.
- dbg_rsp_valid / dbg_rsp_rdata  output  1/32  DBG response.
- dbg_lock  input  1  DBG requests exclusive ownership.
- dbg_locked  output  1  exclusive ownership granted.
- sram_cs / sram_we / sram_wem  output  1/1/4  SRAM chip select, write enable, byte write mask.
- sram_addr / sram_din  output  AW/32  SRAM address and write data.
- sram_dout  input  32  SRAM read data, valid the cycle after sram_cs.

Behaviour:
- Reset: all outputs 0; owner register = NONE; starvation counter = 0; RR pointer = IFU; lock FSM = UNLOCKED.
- Handshake:
  - A request transfers when valid && ready.
  - ready is combinational from the grant; at most one ready is high per cycle.
  - valid may not be withdrawn before ready (protocol rule, checked by assertion).
- Grant cycle: the winner's fields drive sram_cs=1 and sram_we/wem/addr/din in the same cycle; IFU always drives we=0, wem=0.
- Response: exactly 1 cycle after the grant, <winner>_rsp_valid=1 for one cycle and rsp_rdata=sram_dout.
  - Writes also return rsp_valid as an acknowledge.
  - Responses cannot be back-pressured.
  - The owner register records the winner for the response.
- Throughput: back-to-back grants every cycle (pipelined); grant in cycle N and response of N-1 may coincide for different requesters.
- Arbitration, fixed priority (default): DBG > LSU > IFU.
  - Starvation counter increments when IFU is valid and not granted; resets to 0 when IFU is granted or not valid.
  - When counter == STARVE_MAX-1, IFU wins over LSU (not over DBG) next and the counter clears.
- Lock FSM:
  - UNLOCKED --dbg_lock--> DRAIN.
  - DRAIN: no new IFU/LSU grants; DBG still granted. When no response is in flight (owner==NONE after this cycle) --> LOCKED, dbg_locked=1.
  - LOCKED: only DBG granted. On !dbg_lock --> UNLOCKED and dbg_locked=0 next cycle.
  - dbg_lock dropped during DRAIN --> UNLOCKED directly.
- Boundary: addresses wrap modulo 2^AW (no error). wmask=0 with we=1 still issues an access (no byte changes) and is acked.
- Reset mid-operation: an in-flight response is discarded, no rsp_valid after reset, lock released.

Optional Feature:
CIRNO9_ARB_RR_EN
- Defined: IFU and LSU arbitrate round-robin; the RR pointer toggles to the other requester after each IFU/LSU grant. DBG keeps absolute priority and the starvation counter is not built.
- Undefined: fixed priority plus starvation counter, as above.

Decomposition:
- Package cirno9_arb_pkg:
  - owner encoding NONE=0, IFU=1, LSU=2, DBG=3 (2-bit);
  - lock state encoding UNLOCKED/DRAIN/LOCKED;
  - default AW and STARVE_MAX.
- One natural sub-module: cirno9_arb_lock_fsm, holding the lock FSM and producing the allow_ifu_lsu and dbg_locked outputs.
- Grant, owner and counter logic stay in the top module.

Test Plan:
- IFU read at addr 0x010, SRAM word 0x00000013 -> ifu_req_ready same cycle, sram_cs=1 addr=0x010 we=0, ifu_rsp_valid next cycle with rdata 0x00000013.
- LSU and IFU valid in the same cycle, LSU write 0xDEADBEEF wmask 4'b0011 to 0x020 -> LSU granted first (sram_wem=0011); IFU granted the next cycle; lsu_rsp_valid and IFU grant coincide.
- LSU held valid continuously with IFU valid, fixed priority and STARVE_MAX=8 -> IFU granted on the 8th cycle, then LSU resumes. With CIRNO9_ARB_RR_EN -> strict alternation IFU/LSU.
- LSU read in flight, then dbg_lock=1 -> dbg_locked=1 only after lsu_rsp_valid; LSU/IFU ready stay 0 while locked; DBG write 0x12345678 to 0x3FFF acked; dbg_lock=0 -> IFU granted next cycle.
- Address 0x4000 with AW=14 -> sram_addr=0x0000.
- rst_n asserted the cycle after a DBG read grant -> no dbg_rsp_valid, all outputs 0, dbg_locked=0.

Source files
------------

// File: rtl/cirno9_arb_pkg.sv
// Shared encodings and defaults for the cirno9 unified-SRAM arbiter.
package cirno9_arb_pkg;

  localparam int DEF_AW         = 14;
  localparam int DEF_STARVE_MAX = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFU  = 2'd1,
    OWN_LSU  = 2'd2,
    OWN_DBG  = 2'd3
  } owner_e;

  typedef enum logic [1:0] {
    LK_UNLOCKED = 2'd0,
    LK_DRAIN    = 2'd1,
    LK_LOCKED   = 2'd2
  } lock_state_e;

endpackage

// File: rtl/cirno9_arb_lock_fsm.sv
// Debug lock FSM: drains in-flight IFU/LSU traffic, then hands the SRAM
// exclusively to the debug port until dbg_lock is released.
module cirno9_arb_lock_fsm
  import cirno9_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic dbg_lock,
  input  logic owner_idle_next,
  output logic allow_ifu_lsu,
  output logic dbg_locked
);

  lock_state_e state_q, state_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LK_UNLOCKED;
    else        state_q <= state_d;
  end

  // NOTE: state_d is given a default before any branch so the block can never
  // infer a latch when a path leaves it unassigned.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LK_UNLOCKED: if (dbg_lock) state_d = LK_DRAIN;
      LK_DRAIN: begin
        if (!dbg_lock)            state_d = LK_UNLOCKED;
        else if (owner_idle_next) state_d = LK_LOCKED;
      end
      LK_LOCKED:   if (!dbg_lock) state_d = LK_UNLOCKED;
      default:     state_d = LK_UNLOCKED;
    endcase
  end

  assign allow_ifu_lsu = (state_q == LK_UNLOCKED);
  assign dbg_locked    = (state_q == LK_LOCKED);

endmodule

// File: rtl/cirno9_sram_arb.sv
// Single-port SRAM arbiter for IFU / LSU / DBG with one-cycle response return.
// Build option CIRNO9_ARB_RR_EN: round-robin IFU/LSU instead of fixed priority + starvation counter.
module cirno9_sram_arb
  import cirno9_arb_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ifu_req_valid,
  output logic          ifu_req_ready,
  input  logic [AW-1:0] ifu_req_addr,
  output logic          ifu_rsp_valid,
  output logic [31:0]   ifu_rsp_rdata,
  input  logic          lsu_req_valid,
  output logic          lsu_req_ready,
  input  logic [AW-1:0] lsu_req_addr,
  input  logic          lsu_req_we,
  input  logic [31:0]   lsu_req_wdata,
  input  logic [3:0]    lsu_req_wmask,
  output logic          lsu_rsp_valid,
  output logic [31:0]   lsu_rsp_rdata,
  input  logic          dbg_req_valid,
  output logic          dbg_req_ready,
  input  logic [AW-1:0] dbg_req_addr,
  input  logic          dbg_req_we,
  input  logic [31:0]   dbg_req_wdata,
  input  logic [3:0]    dbg_req_wmask,
  output logic          dbg_rsp_valid,
  output logic [31:0]   dbg_rsp_rdata,
  input  logic          dbg_lock,
  output logic          dbg_locked,
  output logic          sram_cs,
  output logic          sram_we,
  output logic [3:0]    sram_wem,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_din,
  input  logic [31:0]   sram_dout
);

  owner_e grant;
  owner_e owner_q;
  logic   allow_ifu_lsu;
  logic   ifu_ok;
  logic   lsu_ok;

  assign ifu_ok = ifu_req_valid && allow_ifu_lsu;
  assign lsu_ok = lsu_req_valid && allow_ifu_lsu;

`ifdef CIRNO9_ARB_RR_EN
  logic rr_lsu_q;  // set when LSU holds the tie-break

  always_comb begin
    grant = OWN_NONE;
    if (dbg_req_valid)       grant = OWN_DBG;
    else if (ifu_ok && lsu_ok) grant = rr_lsu_q ? OWN_LSU : OWN_IFU;
    else if (ifu_ok)         grant = OWN_IFU;
    else if (lsu_ok)         grant = OWN_LSU;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 rr_lsu_q <= 1'b0;
    else if (grant == OWN_IFU)  rr_lsu_q <= 1'b1;
    else if (grant == OWN_LSU)  rr_lsu_q <= 1'b0;
  end
`else
  localparam int            CW         = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX - 1);

  logic [CW-1:0] starve_q;
  logic          ifu_starved;

  assign ifu_starved = (starve_q == STARVE_LIM);

  always_comb begin
    grant = OWN_NONE;
    if (dbg_req_valid)              grant = OWN_DBG;
    else if (ifu_ok && ifu_starved) grant = OWN_IFU;
    else if (lsu_ok)                grant = OWN_LSU;
    else if (ifu_ok)                grant = OWN_IFU;
  end

  // Saturates at the limit so a long DBG burst still leaves IFU first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   starve_q <= '0;
    else if (!ifu_req_valid || grant == OWN_IFU)  starve_q <= '0;
    else if (!ifu_starved)                        starve_q <= starve_q + CW'(1);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) owner_q <= OWN_NONE;
    else        owner_q <= grant;
  end

  cirno9_arb_lock_fsm u_lock_fsm (
    .clk             (clk),
    .rst_n           (rst_n),
    .dbg_lock        (dbg_lock),
    .owner_idle_next (grant == OWN_NONE),
    .allow_ifu_lsu   (allow_ifu_lsu),
    .dbg_locked      (dbg_locked)
  );

  assign ifu_req_ready = (grant == OWN_IFU);
  assign lsu_req_ready = (grant == OWN_LSU);
  assign dbg_req_ready = (grant == OWN_DBG);

  always_comb begin
    sram_cs   = (grant != OWN_NONE);
    sram_we   = 1'b0;
    sram_wem  = '0;
    sram_addr = '0;
    sram_din  = '0;
    unique case (grant)
      OWN_IFU: sram_addr = ifu_req_addr;
      OWN_LSU: begin
        sram_we   = lsu_req_we;
        sram_wem  = lsu_req_wmask;
        sram_addr = lsu_req_addr;
        sram_din  = lsu_req_wdata;
      end
      OWN_DBG: begin
        sram_we   = dbg_req_we;
        sram_wem  = dbg_req_wmask;
        sram_addr = dbg_req_addr;
        sram_din  = dbg_req_wdata;
      end
      default: ;
    endcase
  end

  // Read data is steered only to the owner so idle ports present zero.
  assign ifu_rsp_valid = (owner_q == OWN_IFU);
  assign lsu_rsp_valid = (owner_q == OWN_LSU);
  assign dbg_rsp_valid = (owner_q == OWN_DBG);
  assign ifu_rsp_rdata = ifu_rsp_valid ? sram_dout : '0;
  assign lsu_rsp_rdata = lsu_rsp_valid ? sram_dout : '0;
  assign dbg_rsp_rdata = dbg_rsp_valid ? sram_dout : '0;

  a_ifu_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (ifu_req_valid && !ifu_req_ready) |=> ifu_req_valid);
  a_lsu_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (lsu_req_valid && !lsu_req_ready) |=> lsu_req_valid);
  a_dbg_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (dbg_req_valid && !dbg_req_ready) |=> dbg_req_valid);
  a_one_ready: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({ifu_req_ready, lsu_req_ready, dbg_req_ready}));

endmodule
